// File: rtl/limbus_state_ram_pkg.sv
// Shared definitions for the limbus lookahead state RAM.
//   - clog2: elaboration-time ceiling log2 used to size address buses
//   - ST_CLEAR / ST_RUN: controller state encodings
//   - be_merge: per-bit select between the old stored bit and a new write bit
package limbus_state_ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) < value) begin
        result = r + 1;
      end
    end
    return result;
  endfunction

  // Bit-level merge: the caller expands the symbol byte-enable to each bit.
  function automatic logic be_merge(input logic old_bit, input logic new_bit, input logic be);
    return be ? new_bit : old_bit;
  endfunction

endpackage

// File: rtl/limbus_state_ram_rdport.sv
// One read port of the state RAM with its own copy of the storage array.
// Every copy receives the same internal write port, so all copies hold identical contents
// and each one maps onto a simple dual-port RAM (one write, one registered read).
//   clk, reset_n     clock, asynchronous active-low reset (clears only the output flags)
//   clearing         1 while the owner is sweeping CLEAR_VALUE; forces the read result
//   mem_we/addr/data/be  internal write port (sweep or accepted user write)
//   rd_address       read address, sampled every edge
//   rd_readdata      read result, valid for one cycle after the sampling edge
module limbus_state_ram_rdport
  import limbus_state_ram_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int SYMBOL_WIDTH = 8,
  parameter int AW           = 4,
  parameter int BE_W         = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clearing,
  input  logic                  mem_we,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [BE_W-1:0]       mem_be,
  input  logic [AW-1:0]         rd_address,
  output logic [DATA_WIDTH-1:0] rd_readdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  byp_d, byp_q;
  logic                  force_d, force_q;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    // Same-edge write to the address being read: the array read returns the old word,
    // so remember to overlay the enabled lanes of this write.
    byp_d   = mem_we && (mem_addr == rd_address);
    force_d = clearing || ({1'b0, rd_address} >= DEPTH_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_q   <= 1'b0;
      force_q <= 1'b1;
    end else begin
      byp_q   <= byp_d;
      force_q <= force_d;
    end
  end

  // Storage with per-symbol write enables and read-before-write registered output.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int li = 0; li < BE_W; li++) begin
        if (mem_be[li]) begin
          mem[mem_addr][li*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= mem_data[li*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
      end
    end
    ram_q   <= mem[rd_address];
    wdata_q <= mem_data;
    be_q    <= mem_be;
  end

  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign merged[gi] = be_merge(ram_q[gi], wdata_q[gi], be_q[gi / SYMBOL_WIDTH]);
  end

  assign rd_readdata = force_q ? CLEAR_VALUE : (byp_q ? merged : ram_q);

endmodule

// File: rtl/limbus_sys_state_ram_mp.sv
// Lookahead per-channel state RAM: one byte-enabled write port, NUM_RD registered read ports,
// clear sweep after reset (optional) and on a soft-clear pulse.
//   clk, reset_n     clock, asynchronous active-low reset
//   clr              soft-clear request (single-cycle pulse)
//   wr_address/wr_writedata/wr_byteenable/wr_write   user write port
//   wr_waitrequest   1 while a clear sweep runs; writes are not accepted
//   rd_address       packed read addresses, port i = [i*AW +: AW]
//   rd_readdata      packed read data, port i = [i*DATA_WIDTH +: DATA_WIDTH], latency 1
module limbus_sys_state_ram_mp
  import limbus_state_ram_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int SYMBOL_WIDTH   = 8,
  parameter int NUM_RD         = 2,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int AW   = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1,
  localparam int BE_W = DATA_WIDTH / SYMBOL_WIDTH
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic [AW-1:0]                wr_address,
  input  logic [DATA_WIDTH-1:0]        wr_writedata,
  input  logic [BE_W-1:0]              wr_byteenable,
  input  logic                         wr_write,
  output logic                         wr_waitrequest,
  input  logic [NUM_RD*AW-1:0]         rd_address,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [0:0]    ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [0:0]            state_d, state_q;
  logic [AW-1:0]         cnt_d, cnt_q;
  logic                  wreq_d, wreq_q;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [BE_W-1:0]       mem_be;
  logic                  clearing;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wreq_d   = wreq_q;
    mem_we   = 1'b0;
    mem_addr = wr_address;
    mem_data = wr_writedata;
    mem_be   = wr_byteenable;
    if (state_q == ST_CLEAR) begin
      // Sweep owns the write port: one word per edge, counting down to 0.
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_data = CLEAR_VALUE;
      mem_be   = '1;
      if (clr) begin
        cnt_d = LAST;
      end else if (cnt_q == '0) begin
        state_d = ST_RUN;
        wreq_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end else begin
      // wreq_q can still be high here for one cycle after reset when no sweep is configured.
      mem_we = wr_write && !wreq_q && ({1'b0, wr_address} < DEPTH_W);
      if (clr) begin
        state_d = ST_CLEAR;
        cnt_d   = LAST;
        wreq_d  = 1'b1;
      end else begin
        wreq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      cnt_q   <= LAST;
      wreq_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wreq_q  <= wreq_d;
    end
  end

  assign clearing       = (state_q == ST_CLEAR);
  assign wr_waitrequest = wreq_q;

  genvar gi;
  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    limbus_state_ram_rdport #(
      .DEPTH        (DEPTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .AW           (AW),
      .BE_W         (BE_W),
      .CLEAR_VALUE  (CLEAR_VALUE)
    ) u_rdport (
      .clk         (clk),
      .reset_n     (reset_n),
      .clearing    (clearing),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_be      (mem_be),
      .rd_address  (rd_address[gi*AW +: AW]),
      .rd_readdata (rd_readdata[gi*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
